prog_load_ctrl: RTL
===================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10000000, max cycles between UART writes before fault.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, cycles CPU is held in reset after load completes.
REQ-003 SHALL have port clock  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_pg  in  1  one-cycle pulse (debounced button) requesting program load.
REQ-006 SHALL have port upg_wen_i  in  1  UART write strobe (level), already synchronous to clock.
REQ-007 SHALL have port upg_adr_i  in  15  bit 14: 0=instruction memory, 1=data memory; [13:0] word address.
REQ-008 SHALL have port upg_dat_i  in  32  UART write data.
REQ-009 SHALL have port upg_done_i  in  1  level; high when UART transfer finished.
REQ-010 SHALL have port upg_rst_o  out  1  high holds UART receiver idle.
REQ-011 SHALL have port cpu_rst_o  out  1  high holds CPU pipeline in reset.
REQ-012 SHALL have ports imem_we_o, dmem_we_o  out  1 each  one-cycle write strobes.
REQ-013 SHALL have ports mem_adr_o  out  14 and mem_dat_o  out  32  registered write address/data.
REQ-014 SHALL have ports word_cnt_o  out  15  words written this load; state_o  out  3  current state; err_o  out  1  timeout fault.

Function
REQ-015 SHALL implement states RUN, ARMED, LOAD, DRAIN, FAULT.
REQ-016 RUN: upg_rst_o=1, cpu_rst_o=0; start_pg -> ARMED next cycle.
REQ-017 ARMED: upg_rst_o=0, cpu_rst_o=1; write edge -> LOAD; upg_done_i with no write -> DRAIN; timeout -> FAULT.
REQ-018 LOAD: upg_rst_o=0, cpu_rst_o=1; upg_done_i -> DRAIN; timeout -> FAULT.
REQ-019 DRAIN: upg_rst_o=1, cpu_rst_o=1; after exactly DRAIN_CYCLES cycles -> RUN.
REQ-020 FAULT: upg_rst_o=1, cpu_rst_o=1, err_o=1; start_pg -> ARMED and clears err_o.
REQ-021 start_pg SHALL be ignored in ARMED, LOAD, DRAIN.
REQ-022 Write edge = upg_wen_i rising edge (1 now, 0 previous cycle); one forwarded write per edge regardless of strobe length.
REQ-023 Write edge in ARMED/LOAD SHALL produce, next cycle, exactly one of imem_we_o/dmem_we_o (per upg_adr_i[14]) high for one cycle with mem_adr_o/mem_dat_o captured from the edge cycle.
REQ-024 Write edges in RUN, DRAIN, FAULT SHALL be ignored (no strobe, no count).
REQ-025 Write edge and upg_done_i in the same LOAD cycle: write forwarded, then DRAIN.
REQ-026 word_cnt_o SHALL clear on entry to ARMED, increment per forwarded write, saturate at 32767; held in other states.
REQ-027 Timeout counter SHALL clear on entry to ARMED and on each write edge; fault when it reaches TIMEOUT_CYCLES with no edge and no upg_done_i.
REQ-028 mem_adr_o/mem_dat_o SHALL hold last captured value when no strobe.

Reset
REQ-029 On reset: state RUN, upg_rst_o=1, cpu_rst_o=0, strobes 0, mem_adr_o=0, mem_dat_o=0, word_cnt_o=0, err_o=0, edge history=0, counters=0.
REQ-030 Reset in any state (including mid-LOAD) SHALL take effect next edge; pending strobe suppressed.

Structure
REQ-031 State encoding (RUN=0, ARMED=1, LOAD=2, DRAIN=3, FAULT=4) and memory-select bit index (14) SHALL live in the shared CPU package.
REQ-032 Rising-edge detector SHALL be one sub-module, pulse_rise; all else in prog_load_ctrl.

Verification
REQ-033 reset, then start_pg -> state_o=1, upg_rst_o=0, cpu_rst_o=1 next cycle.
REQ-034 ARMED, upg_wen_i high 3 cycles, adr=0x0005, dat=0xDEADBEEF -> one imem_we_o pulse, mem_adr_o=0x0005, mem_dat_o=0xDEADBEEF, word_cnt_o=1, state LOAD.
REQ-035 LOAD, edge adr=0x4010 dat=0x12345678 with upg_done_i same cycle -> dmem_we_o pulse adr 0x0010, then DRAIN 4 cycles, RUN, cpu_rst_o=0.
REQ-036 TIMEOUT_CYCLES=16, ARMED, no activity 16 cycles -> FAULT, err_o=1; start_pg -> ARMED, err_o=0, word_cnt_o=0.
REQ-037 reset asserted in LOAD one cycle after edge -> no strobe, state RUN, word_cnt_o=0.
REQ-038 start_pg during LOAD and write edge in RUN -> no state change, no strobe.

Source files
------------

// File: rtl/prog_load_ctrl_pkg.sv
// Shared CPU package: loader state encoding and memory-select bit position.
// Imported by the program-load controller and anything that decodes state_o.
package prog_load_ctrl_pkg;

  // Loader states; the numeric values are visible on state_o.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_ARMED = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } load_state_e;

  // Bit of the UART address that selects data memory (1) or instruction memory (0).
  localparam int MEM_SEL_BIT = 14;

endpackage

// File: rtl/prog_load_ctrl_pulse_rise.sv
// Purpose: rising-edge detector, rise = sig now high and low on the previous cycle.
// Latency: combinational from sig (history register adds one cycle of memory).
// Backpressure: none; one pulse per rising edge however long sig stays high.
// Ports: clock, reset (sync, active-high), sig (level in), rise (one-cycle pulse out).
module pulse_rise (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sig_prev <= 1'b0;
    end else begin
      sig_prev <= sig;
    end
  end

  assign rise = sig & ~sig_prev;

endmodule

// File: rtl/prog_load_ctrl.sv
// Purpose: sequences a UART program load - holds the CPU in reset, forwards UART writes
//   to instruction/data memory, drains, then releases the CPU; faults on UART silence.
// Latency: write strobe/address/data one cycle after the upg_wen_i rising edge.
// Backpressure: none; UART writes are taken as they come, one per rising edge of upg_wen_i.
// Ports: clock/reset (sync, active-high); start_pg load request; upg_* UART write side;
//   upg_rst_o/cpu_rst_o hold controls; imem_we_o/dmem_we_o/mem_adr_o/mem_dat_o memory write;
//   word_cnt_o words written this load; state_o current state; err_o timeout fault.
module prog_load_ctrl #(
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_pg,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        imem_we_o,
  output logic        dmem_we_o,
  output logic [13:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic [14:0] word_cnt_o,
  output logic [2:0]  state_o,
  output logic        err_o
);

  import prog_load_ctrl_pkg::*;

  // Counters only need to reach LIMIT-1; the transition fires on that value.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [14:0]   WORD_MAX   = 15'h7FFF;

  load_state_e   state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [DW-1:0] drain_cnt;
  logic          wr_rise;
  logic          fwd;
  logic          arm_entry;
  logic          drain_entry;
  logic          tmo_hit;
  logic          drain_hit;

  pulse_rise u_wen_rise (
    .clock (clock),
    .reset (reset),
    .sig   (upg_wen_i),
    .rise  (wr_rise)
  );

  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign drain_hit   = (drain_cnt == DRAIN_LAST);
  // Only edges seen while the loader owns the memories are forwarded.
  assign fwd         = wr_rise && ((state == ST_ARMED) || (state == ST_LOAD));
  assign arm_entry   = (state_nxt == ST_ARMED) && (state != ST_ARMED);
  assign drain_entry = (state_nxt == ST_DRAIN) && (state != ST_DRAIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_RUN;
      tmo_cnt    <= '0;
      drain_cnt  <= '0;
      imem_we_o  <= 1'b0;
      dmem_we_o  <= 1'b0;
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      word_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      imem_we_o <= fwd & ~upg_adr_i[MEM_SEL_BIT];
      dmem_we_o <= fwd &  upg_adr_i[MEM_SEL_BIT];
      if (fwd) begin
        mem_adr_o <= upg_adr_i[13:0];
        mem_dat_o <= upg_dat_i;
      end

      if (arm_entry) begin
        word_cnt_o <= '0;
      end else if (fwd && (word_cnt_o != WORD_MAX)) begin
        word_cnt_o <= word_cnt_o + 15'd1;
      end

      // Measures silence since arming or since the most recent write edge.
      if (arm_entry || wr_rise) begin
        tmo_cnt <= '0;
      end else if ((state == ST_ARMED) || (state == ST_LOAD)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (drain_entry) begin
        drain_cnt <= '0;
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    upg_rst_o = 1'b1;
    cpu_rst_o = 1'b1;
    err_o     = 1'b0;
    unique case (state)
      ST_RUN: begin
        cpu_rst_o = 1'b0;
        if (start_pg) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        upg_rst_o = 1'b0;
        // A write with done in the same cycle goes to LOAD; done still high there drains.
        if (wr_rise)         state_nxt = ST_LOAD;
        else if (upg_done_i) state_nxt = ST_DRAIN;
        else if (tmo_hit)    state_nxt = ST_FAULT;
      end
      ST_LOAD: begin
        upg_rst_o = 1'b0;
        if (upg_done_i)               state_nxt = ST_DRAIN;
        else if (!wr_rise && tmo_hit) state_nxt = ST_FAULT;
      end
      ST_DRAIN: begin
        if (drain_hit) state_nxt = ST_RUN;
      end
      ST_FAULT: begin
        err_o = 1'b1;
        if (start_pg) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign state_o = state;

endmodule
